capture_trigger_ctrl: RTL and testbench
=======================================

// Module: capture_trigger_ctrl
// PURPOSE
//  Acquisition front end that feeds the 64x1K sample BRAM in the capture/readback stage.
//  - After an arm pulse, writes one 64-bit probe sample per clock into the buffer as a circular write.
//  - Qualifies a masked-pattern trigger and stops after a programmed post-trigger count.
//  - Reports where the oldest sample and the trigger sample sit, so the host can read the 1K window in order.
// PARAMETERS
//  DATA_W  64  probe sample width
//  ADDR_W  10  buffer address width; DEPTH = 2**ADDR_W = 1024 samples
// PORTS
//  in_clk          in   1       sample clock; single clock domain
//  in_rst_n        in   1       reset, asynchronous, active-low
//  in_arm          in   1       1-cycle pulse; starts an acquisition
//  in_abort        in   1       1-cycle pulse; cancels the acquisition
//  in_trig_mask    in   DATA_W  1 = bit participates in the trigger compare
//  in_trig_value   in   DATA_W  trigger pattern
//  in_post_count   in   ADDR_W  samples written after the trigger sample; latched at arm
//  in_data         in   DATA_W  probe sample, valid every cycle
//  out_we          out  1       buffer write strobe (drives BRAM ce/we)
//  out_addr        out  ADDR_W  buffer write address
//  out_data        out  DATA_W  buffer write data
//  out_busy        out  1       acquisition in progress
//  out_triggered   out  1       trigger accepted in the current/last run
//  out_done        out  1       window complete; held until next arm or reset
//  out_trig_addr   out  ADDR_W  buffer address of the trigger sample
//  out_start_addr  out  ADDR_W  buffer address of the oldest sample in the window
// BEHAVIOUR
//  - Reset (async, in_rst_n=0): state IDLE; all outputs 0; wr_ptr, pre_cnt and post_cnt 0.
//  - Pre-trigger fill length: PRE = DEPTH-1-post_count, computed at arm.
//  - Window size: PRE + 1 + post_count = DEPTH exactly.
//  - Match condition (combinational on in_data): ((in_data ^ in_trig_value) & in_trig_mask) == 0.
//    Mask all-zero makes the trigger fire on the first eligible sample.
//  - FSM states: IDLE, FILL, ARMED, POST, DONE.
//    - IDLE/DONE + in_arm: on that edge latch post_count, pre_cnt<=PRE, wr_ptr<=0.
//      Clear out_done and out_triggered; go to FILL, or to ARMED if PRE==0.
//    - FILL/ARMED/POST, every edge:
//      out_we<=1, out_addr<=wr_ptr, out_data<=in_data, wr_ptr<=wr_ptr+1 mod DEPTH.
//      Write latency is 1 cycle: in_data at edge k appears on out_* after edge k.
//    - FILL: pre_cnt decrements per sample; the trigger is ignored.
//      The edge writing the PRE-th sample goes to ARMED.
//    - ARMED: writes continue and wrap indefinitely.
//      The first matching sample is the trigger: out_trig_addr<=wr_ptr, out_triggered<=1.
//      Then go to POST, or directly to DONE if post_count==0.
//    - POST: post_cnt decrements per sample; the edge writing the last sample goes to DONE.
//    - DONE: out_we<=0, out_done<=1, out_busy<=0, out_start_addr<=wr_ptr after the final increment.
//  - out_busy = 1 in FILL/ARMED/POST.
//  - in_arm while busy: ignored.
//  - in_abort in FILL/ARMED/POST: IDLE on that edge; out_we=0 next cycle; out_done stays 0.
//    out_triggered keeps its value.
//  - in_arm and in_abort in the same cycle: abort wins (from DONE: goes to IDLE and clears out_done).
//  - Reset mid-run: immediate return to reset values; the partial buffer content is undefined to the host.
// STRUCTURE
//  - Shared package dla_pkg: DATA_W, ADDR_W, DEPTH constants; FSM state encoding (5 states, 3 bits).
//  - One sub-module, trig_match: mask/value compare, purely combinational, DATA_W-wide.
//  - The top holds the FSM, the counters, wr_ptr and the output registers.
// TESTING
//  1. Reset mid-run (in ARMED): out_we=0, out_addr=0, out_busy=0, out_done=0 asynchronously; no further writes.
//  2. in_data=counter from 0, mask=0, post=256, arm:
//     - FILL for 767 samples; trigger at addr 767.
//     - Exactly 1024 writes (addr 0..1023); done, trig_addr=767, start_addr=0.
//  3. mask=0xFF, value=0x5A, post=256, counter data starting 0:
//     - low byte 0x5A at sample 90 is ignored (still FILL).
//     - Trigger at first 0x5A after sample 767, i.e. sample 858, addr 858.
//     - Done after 1115 writes; start_addr=(1115 mod 1024)=91.
//  4. post=1023, mask=0: PRE=0, trigger at addr 0, 1023 post writes; done, trig_addr=0, start_addr=0.
//  5. post=0: trigger is the last write; done the next cycle; trig_addr = start_addr-1 mod 1024.
//  6. Abort and arm handling:
//     - Abort in POST: out_we=0 next cycle, out_done=0, out_busy=0.
//     - Arm while busy changes nothing.
//     - Arm+abort in the same cycle from DONE: state IDLE, out_done=0.

Source files
------------

// File: rtl/dla_pkg.sv
// Shared definitions for the capture/trigger acquisition front end.
//   DATA_W : probe sample width
//   ADDR_W : sample buffer address width
//   DEPTH  : number of samples in the circular buffer (2**ADDR_W)
//   state_e: acquisition FSM encoding (5 states, 3 bits)
//   pre_len: number of samples to fill before the trigger is qualified
package dla_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Pre-trigger length chosen so that pre + trigger + post == DEPTH.
  function automatic logic [ADDR_W-1:0] pre_len(input logic [ADDR_W-1:0] post);
    return ADDR_W'(DEPTH - 1) - post;
  endfunction

endpackage

// File: rtl/capture_trigger_ctrl_if.sv
// Control/sample/buffer-write bundle of the capture trigger controller.
//   in_arm / in_abort     : single-cycle command pulses from the host
//   in_trig_mask/_value   : masked trigger pattern
//   in_post_count         : post-trigger sample count, latched at arm
//   in_data               : probe sample, valid every clock
//   out_we/out_addr/out_data : buffer write port
//   out_busy/out_triggered/out_done/out_trig_addr/out_start_addr : status
//
// Handshake semantics: there is no backpressure anywhere. in_data is
// consumed on every clock edge while an acquisition runs; out_we is a
// one-cycle write strobe and out_addr/out_data are meaningful only in a
// cycle where out_we is 1. Command pulses are sampled on each rising edge.
interface capture_trigger_ctrl_if;
  import dla_pkg::*;

  logic              in_arm;
  logic              in_abort;
  logic [DATA_W-1:0] in_trig_mask;
  logic [DATA_W-1:0] in_trig_value;
  logic [ADDR_W-1:0] in_post_count;
  logic [DATA_W-1:0] in_data;

  logic              out_we;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_busy;
  logic              out_triggered;
  logic              out_done;
  logic [ADDR_W-1:0] out_trig_addr;
  logic [ADDR_W-1:0] out_start_addr;

  modport master (
    output in_arm, in_abort, in_trig_mask, in_trig_value, in_post_count, in_data,
    input  out_we, out_addr, out_data, out_busy, out_triggered, out_done,
           out_trig_addr, out_start_addr
  );

  modport slave (
    input  in_arm, in_abort, in_trig_mask, in_trig_value, in_post_count, in_data,
    output out_we, out_addr, out_data, out_busy, out_triggered, out_done,
           out_trig_addr, out_start_addr
  );

endinterface

// File: rtl/capture_trigger_ctrl_trig_match.sv
// Masked pattern compare, purely combinational.
//   data  : sample under test
//   value : trigger pattern
//   mask  : 1 = bit participates in the compare
//   hit   : all participating bits equal (an all-zero mask always hits)
module trig_match #(
  parameter int W = 64
) (
  input  logic [W-1:0] data,
  input  logic [W-1:0] value,
  input  logic [W-1:0] mask,
  output logic         hit
);

  assign hit = (((data ^ value) & mask) == '0);

endmodule

// File: rtl/capture_trigger_ctrl.sv
// Acquisition front end for the capture sample buffer.
// After an arm pulse it writes one sample per clock into a circular buffer,
// fills the pre-trigger part, waits for a masked-pattern trigger, writes the
// programmed number of post-trigger samples and then reports where the
// trigger sample and the oldest sample of the window sit.
//   in_clk, in_rst_n : clock, asynchronous active-low reset
//   bus              : control, sample input, buffer write port and status
//   dbg_state        : current FSM state, for observation only
module capture_trigger_ctrl
  import dla_pkg::*;
(
  input  logic                   in_clk,
  input  logic                   in_rst_n,
  capture_trigger_ctrl_if.slave  bus,
  output state_e                 dbg_state
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0] post_len_q, post_len_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              triggered_q, triggered_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] start_addr_q, start_addr_d;
  logic              hit;
  logic [ADDR_W-1:0] pre_at_arm;

  trig_match #(.W(DATA_W)) u_trig_match (
    .data  (bus.in_data),
    .value (bus.in_trig_value),
    .mask  (bus.in_trig_mask),
    .hit   (hit)
  );

  assign pre_at_arm = pre_len(bus.in_post_count);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    pre_cnt_d    = pre_cnt_q;
    post_cnt_d   = post_cnt_q;
    post_len_d   = post_len_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    triggered_d  = triggered_q;
    done_d       = done_q;
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE) begin
          done_d       = 1'b1;
          // wr_ptr already points one past the last write: the oldest sample.
          start_addr_d = wr_ptr_q;
        end
        if (bus.in_abort) begin
          // Abort beats a simultaneous arm; from DONE it also drops done.
          if (bus.in_arm) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
          end
        end else if (bus.in_arm) begin
          post_len_d  = bus.in_post_count;
          pre_cnt_d   = pre_at_arm;
          wr_ptr_d    = '0;
          done_d      = 1'b0;
          triggered_d = 1'b0;
          state_d     = (pre_at_arm == '0) ? ST_ARMED : ST_FILL;
        end
      end

      ST_FILL, ST_ARMED, ST_POST: begin
        if (bus.in_abort) begin
          state_d = ST_IDLE;
        end else begin
          we_d     = 1'b1;
          addr_d   = wr_ptr_q;
          data_d   = bus.in_data;
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          if (state_q == ST_FILL) begin
            // Trigger is not qualified until the pre-trigger part is full.
            pre_cnt_d = pre_cnt_q - ADDR_W'(1);
            if (pre_cnt_q == ADDR_W'(1)) state_d = ST_ARMED;
          end else if (state_q == ST_ARMED) begin
            if (hit) begin
              trig_addr_d = wr_ptr_q;
              triggered_d = 1'b1;
              post_cnt_d  = post_len_q;
              state_d     = (post_len_q == '0) ? ST_DONE : ST_POST;
            end
          end else begin
            post_cnt_d = post_cnt_q - ADDR_W'(1);
            if (post_cnt_q == ADDR_W'(1)) state_d = ST_DONE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_FILL) || (state_d == ST_ARMED) || (state_d == ST_POST);
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      post_len_q   <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      busy_q       <= 1'b0;
      triggered_q  <= 1'b0;
      done_q       <= 1'b0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      pre_cnt_q    <= pre_cnt_d;
      post_cnt_q   <= post_cnt_d;
      post_len_q   <= post_len_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
      triggered_q  <= triggered_d;
      done_q       <= done_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
    end
  end

  assign bus.out_we         = we_q;
  assign bus.out_addr       = addr_q;
  assign bus.out_data       = data_q;
  assign bus.out_busy       = busy_q;
  assign bus.out_triggered  = triggered_q;
  assign bus.out_done       = done_q;
  assign bus.out_trig_addr  = trig_addr_q;
  assign bus.out_start_addr = start_addr_q;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_capture_trigger_ctrl.sv
// Bench for capture_trigger_ctrl: directed runs with a sample-index model.
module tb_capture_trigger_ctrl;
  import dla_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  capture_trigger_ctrl_if bus();
  state_e dbg_state;

  capture_trigger_ctrl dut (
    .in_clk    (clk),
    .in_rst_n  (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the run by sample index n: sample n lands at address n mod DEPTH,
  // the trigger is the first matching sample with n >= pre, and the run ends
  // with sample trigger+post; done shows up one clock later.
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  bit                m_run      = 0;
  bit                m_done_pnd = 0;
  int                m_n        = 0;
  int                m_trig_n   = -1;
  int                m_pre      = 0;
  int                m_post     = 0;
  logic              exp_we     = 0;
  logic              exp_busy   = 0;
  logic              exp_done   = 0;
  logic              exp_trig   = 0;
  logic [ADDR_W-1:0] exp_trig_addr = '0;
  logic [ADDR_W-1:0] exp_start     = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_run = 0; m_done_pnd = 0; m_n = 0; m_trig_n = -1; m_pre = 0; m_post = 0;
      exp_we = 0; exp_busy = 0; exp_done = 0; exp_trig = 0;
      exp_trig_addr = '0; exp_start = '0;
    end else begin
      exp_q.delete();
      exp_we = 0;
      if (m_run) begin
        if (bus.in_abort) begin
          m_run = 0;
        end else begin
          exp_we = 1;
          exp_q.push_back({ADDR_W'(m_n % DEPTH), bus.in_data});
          if (m_trig_n < 0 && m_n >= m_pre &&
              ((bus.in_data ^ bus.in_trig_value) & bus.in_trig_mask) == 64'd0) begin
            m_trig_n      = m_n;
            exp_trig      = 1;
            exp_trig_addr = ADDR_W'(m_n % DEPTH);
          end
          if (m_trig_n >= 0 && m_n == m_trig_n + m_post) begin
            m_run      = 0;
            m_done_pnd = 1;
          end
          m_n++;
        end
      end else begin
        if (bus.in_abort && bus.in_arm) begin
          m_done_pnd = 0;
          exp_done   = 0;
        end else if (bus.in_arm) begin
          m_run = 1; m_n = 0; m_trig_n = -1;
          m_post = int'(bus.in_post_count);
          m_pre  = DEPTH - 1 - m_post;
          exp_trig = 0; exp_done = 0; m_done_pnd = 0;
        end else if (m_done_pnd) begin
          m_done_pnd = 0;
          exp_done   = 1;
          exp_start  = ADDR_W'(m_n % DEPTH);
        end
      end
      exp_busy = m_run;
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    logic [ADDR_W+DATA_W-1:0] e;
    if (rst_n) begin
      chk("we", 64'(bus.out_we), 64'(exp_we));
      if (bus.out_we) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: got addr %0h expected no write at %0t", bus.out_addr, $time);
        end else begin
          e = exp_q.pop_front();
          chk("addr", 64'(bus.out_addr), 64'(e[ADDR_W+DATA_W-1:DATA_W]));
          chk("data", bus.out_data, e[DATA_W-1:0]);
        end
      end
      chk("busy", 64'(bus.out_busy), 64'(exp_busy));
      chk("done", 64'(bus.out_done), 64'(exp_done));
      chk("triggered", 64'(bus.out_triggered), 64'(exp_trig));
      if (exp_trig) chk("trig_addr", 64'(bus.out_trig_addr), 64'(exp_trig_addr));
      if (exp_done) chk("start_addr", 64'(bus.out_start_addr), 64'(exp_start));
    end
  end

  // ---------------- driver tasks ----------------
  logic [63:0] cnt = '0;
  int writes = 0, first_trig = -1, done_cyc = -1, last_we_cyc = -1, cyc = 0;

  task automatic step();
    @(negedge clk);
    if (bus.out_we) begin writes++; last_we_cyc = cyc; end
    if (bus.out_triggered && first_trig < 0) first_trig = writes;
    if (bus.out_done && done_cyc < 0) done_cyc = cyc;
    cyc++;
    bus.in_arm   = 1'b0;
    bus.in_abort = 1'b0;
    bus.in_data  = cnt;
    cnt++;
  endtask

  task automatic start_run(input logic [ADDR_W-1:0] post, input logic [63:0] mask,
                           input logic [63:0] value);
    @(negedge clk);
    bus.in_post_count = post;
    bus.in_trig_mask  = mask;
    bus.in_trig_value = value;
    bus.in_arm        = 1'b1;
    bus.in_data       = 64'h0;
    cnt = '0; writes = 0; first_trig = -1; done_cyc = -1; last_we_cyc = -1; cyc = 0;
  endtask

  task automatic run_until_done(input string name, input int budget);
    for (int i = 0; i < budget && done_cyc < 0; i++) step();
    total++;
    if (done_cyc < 0) begin
      bad++;
      $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, budget);
    end
  endtask

  task automatic run_until_writes(input string name, input int n, input int budget);
    for (int i = 0; i < budget && writes < n; i++) step();
    total++;
    if (writes < n) begin
      bad++;
      $display("FAIL %s_timeout: got %0d writes expected %0d", name, writes, n);
    end
  endtask

  task automatic finish_checks(input string name, input int exp_writes, input int exp_ta,
                               input int exp_sa, input int exp_first);
    chk({name, "_writes"}, 64'(writes), 64'(exp_writes));
    chk({name, "_trig_addr"}, 64'(bus.out_trig_addr), 64'(exp_ta));
    chk({name, "_start_addr"}, 64'(bus.out_start_addr), 64'(exp_sa));
    chk({name, "_writes_at_trigger"}, 64'(first_trig), 64'(exp_first));
    chk({name, "_done_latency"}, 64'(done_cyc), 64'(last_we_cyc + 1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.in_arm = 0; bus.in_abort = 0; bus.in_trig_mask = '0;
    bus.in_trig_value = '0; bus.in_post_count = '0; bus.in_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_we", 64'(bus.out_we), 64'd0);
    chk("rst_addr", 64'(bus.out_addr), 64'd0);
    chk("rst_data", bus.out_data, 64'd0);
    chk("rst_busy", 64'(bus.out_busy), 64'd0);
    chk("rst_done", 64'(bus.out_done), 64'd0);
    chk("rst_triggered", 64'(bus.out_triggered), 64'd0);
    chk("rst_trig_addr", 64'(bus.out_trig_addr), 64'd0);
    chk("rst_start_addr", 64'(bus.out_start_addr), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst_n = 1'b1;

    // 1: reset while ARMED (pre = 23, pattern never matches)
    start_run(10'd1000, '1, '1);
    repeat (40) step();
    chk("t1_armed_state", 64'(dbg_state), 64'(ST_ARMED));
    chk("t1_busy", 64'(bus.out_busy), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_we", 64'(bus.out_we), 64'd0);
    chk("t1_async_addr", 64'(bus.out_addr), 64'd0);
    chk("t1_async_busy", 64'(bus.out_busy), 64'd0);
    chk("t1_async_done", 64'(bus.out_done), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("t1_no_write_in_reset", 64'(bus.out_we), 64'd0);
    end
    rst_n = 1'b1;

    // 2: mask 0, post 256 -> trigger at 767, 1024 writes
    start_run(10'd256, '0, '0);
    run_until_done("t2", 1500);
    finish_checks("t2", 1024, 767, 0, 768);

    // 3: low byte 0x5A; sample 90 falls in the fill and is ignored
    start_run(10'd256, 64'hFF, 64'h5A);
    run_until_done("t3", 1600);
    finish_checks("t3", 1115, 858, 91, 859);

    // 4: post 1023 -> no fill, trigger on the very first sample
    start_run(10'd1023, '0, '0);
    run_until_done("t4", 1500);
    finish_checks("t4", 1024, 0, 0, 1);

    // 5: post 0 -> trigger is the last write
    start_run(10'd0, '0, '0);
    run_until_done("t5", 1500);
    finish_checks("t5", 1024, 1023, 0, 1024);

    // 6: arm while busy is ignored, abort in POST, arm+abort from DONE
    start_run(10'd256, '0, '0);
    run_until_writes("t6", 800, 1500);
    bus.in_arm = 1'b1;
    bus.in_post_count = 10'd5;
    step();
    chk("t6_arm_busy_addr", 64'(bus.out_addr), 64'd800);
    chk("t6_arm_busy_busy", 64'(bus.out_busy), 64'd1);
    bus.in_abort = 1'b1;
    step();
    chk("t6_abort_we", 64'(bus.out_we), 64'd0);
    chk("t6_abort_busy", 64'(bus.out_busy), 64'd0);
    chk("t6_abort_done", 64'(bus.out_done), 64'd0);
    chk("t6_abort_triggered", 64'(bus.out_triggered), 64'd1);
    start_run(10'd0, '0, '0);
    run_until_done("t6b", 1500);
    chk("t6_done_before", 64'(bus.out_done), 64'd1);
    bus.in_arm = 1'b1;
    bus.in_abort = 1'b1;
    step();
    chk("t6_armabort_done", 64'(bus.out_done), 64'd0);
    chk("t6_armabort_busy", 64'(bus.out_busy), 64'd0);
    chk("t6_armabort_state", 64'(dbg_state), 64'(ST_IDLE));
    step();
    chk("t6_idle_we", 64'(bus.out_we), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
